// File: rtl/types_pkg.sv
// Shared types for the branch recovery slice: branch FU result record,
// recovery FSM state encoding and ROB tag width.
package types_pkg;

  localparam int ROB_TAG_W = 5;
  localparam int PC_W      = 32;

  // Branch functional-unit result as seen by the recovery unit.
  typedef struct packed {
    logic                 fu_b_done;
    logic                 mispredict;
    logic [ROB_TAG_W-1:0] mispredict_tag;
    logic [PC_W-1:0]      pc;
    logic                 hit;
    logic [ROB_TAG_W-1:0] hit_tag;
  } b_data;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    RESTORE  = 2'd2,
    REDIRECT = 2'd3
  } brec_state_t;

  // Distance of a ROB entry from the head; modular so the ring wraps cleanly.
  function automatic logic [ROB_TAG_W-1:0] rob_age(
    input logic [ROB_TAG_W-1:0] tag,
    input logic [ROB_TAG_W-1:0] head
  );
    rob_age = tag - head;
  endfunction

endpackage

// File: rtl/rob_age_cmp.sv
// ROB age comparator: a_older is set when tag_a is strictly closer to the
// ROB head than tag_b, measured modulo the ROB size.
module rob_age_cmp
  import types_pkg::*;
(
  input  logic [ROB_TAG_W-1:0] tag_a,
  input  logic [ROB_TAG_W-1:0] tag_b,
  input  logic [ROB_TAG_W-1:0] head,
  output logic                 a_older
);

  logic [ROB_TAG_W-1:0] age_a_s;
  logic [ROB_TAG_W-1:0] age_b_s;

  // Convert both tags to head-relative ages and compare them.
  always_comb begin
    age_a_s = rob_age(tag_a, head);
    age_b_s = rob_age(tag_b, head);
    a_older = (age_a_s < age_b_s);
  end

endmodule

// File: rtl/branch_recovery_unit.sv
// Branch misprediction recovery sequencer: flush -> checkpoint restore ->
// fetch redirect, with replacement by an older mispredict at any point.
// Optional feature macro: BRU_PERF_CNT_EN adds mispredict/hit counters.
module branch_recovery_unit
  import types_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROB_TAG_W-1:0] curr_rob_tag,
  input  b_data                b_in,
  input  logic                 restore_ack,
  output logic                 flush,
  output logic [ROB_TAG_W-1:0] flush_tag,
  output logic                 restore_req,
  output logic [ROB_TAG_W-1:0] restore_tag,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 stall_fe,
  output logic                 busy
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]          mispredict_cnt,
  output logic [31:0]          hit_cnt
`endif
);

  brec_state_t          state_r;
  brec_state_t          next_state_s;
  logic [ROB_TAG_W-1:0] tag_q;
  logic [PC_W-1:0]      pc_q;
  logic                 accept_s;
  logic                 older_s;
  logic                 load_s;
  logic                 unused_s;

  // Qualified mispredict; masked while reset is held so nothing stalls in reset.
  assign accept_s = reset & b_in.fu_b_done & b_in.mispredict;

  rob_age_cmp u_age_cmp (
    .tag_a   (b_in.mispredict_tag),
    .tag_b   (tag_q),
    .head    (curr_rob_tag),
    .a_older (older_s)
  );

  // Next-state selection; an older mispredict always restarts at FLUSH.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s       = 1'b1;
          next_state_s = FLUSH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FLUSH: begin
        if (accept_s && older_s) begin
          load_s       = 1'b1;
          next_state_s = FLUSH;
        end else begin
          next_state_s = RESTORE;
        end
      end
      RESTORE: begin
        if (accept_s && older_s) begin
          load_s       = 1'b1;
          next_state_s = FLUSH;
        end else if (restore_ack) begin
          next_state_s = REDIRECT;
        end else begin
          next_state_s = RESTORE;
        end
      end
      REDIRECT: begin
        if (accept_s && older_s) begin
          load_s       = 1'b1;
          next_state_s = FLUSH;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and latched mispredict tag/target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      tag_q   <= {ROB_TAG_W{1'b0}};
      pc_q    <= {PC_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        tag_q <= b_in.mispredict_tag;
        pc_q  <= b_in.pc;
      end else begin
        tag_q <= tag_q;
        pc_q  <= pc_q;
      end
    end
  end

  // Output decode; payloads are zeroed whenever their strobe is low.
  always_comb begin
    flush          = 1'b0;
    flush_tag      = {ROB_TAG_W{1'b0}};
    restore_req    = 1'b0;
    restore_tag    = {ROB_TAG_W{1'b0}};
    redirect_valid = 1'b0;
    redirect_pc    = {PC_W{1'b0}};
    busy           = (state_r != IDLE);
    stall_fe       = 1'b0;
    case (state_r)
      IDLE: begin
        stall_fe = accept_s;
      end
      FLUSH: begin
        stall_fe  = 1'b1;
        flush     = 1'b1;
        flush_tag = tag_q;
      end
      RESTORE: begin
        stall_fe    = 1'b1;
        restore_req = 1'b1;
        restore_tag = tag_q;
      end
      REDIRECT: begin
        stall_fe = 1'b1;
        // An older mispredict this cycle makes the pending target stale.
        if (accept_s && older_s) begin
          redirect_valid = 1'b0;
          redirect_pc    = {PC_W{1'b0}};
        end else begin
          redirect_valid = 1'b1;
          redirect_pc    = pc_q;
        end
      end
      default: begin
        stall_fe = 1'b0;
      end
    endcase
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] mispredict_cnt_r;
  logic [31:0] hit_cnt_r;

  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict_cnt_r <= 32'd0;
      hit_cnt_r        <= 32'd0;
    end else begin
      if (load_s) begin
        mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
      end else begin
        mispredict_cnt_r <= mispredict_cnt_r;
      end
      if (b_in.fu_b_done && b_in.hit) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end else begin
        hit_cnt_r <= hit_cnt_r;
      end
    end
  end

  assign mispredict_cnt = mispredict_cnt_r;
  assign hit_cnt        = hit_cnt_r;
  assign unused_s       = ^b_in.hit_tag;
`else
  // Predictor hit information does not influence recovery.
  assign unused_s = ^{b_in.hit, b_in.hit_tag};
`endif

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Directed bench for branch_recovery_unit: nominal recovery, younger/older
// replacement, tag wrap, suppressed redirect and asynchronous reset.
module tb_branch_recovery_unit;
  import types_pkg::*;

  logic                 clk;
  logic                 reset;
  logic [ROB_TAG_W-1:0] curr_rob_tag;
  b_data                b_in;
  logic                 restore_ack;
  logic                 flush;
  logic [ROB_TAG_W-1:0] flush_tag;
  logic                 restore_req;
  logic [ROB_TAG_W-1:0] restore_tag;
  logic                 redirect_valid;
  logic [PC_W-1:0]      redirect_pc;
  logic                 stall_fe;
  logic                 busy;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]          mispredict_cnt;
  logic [31:0]          hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  branch_recovery_unit dut (
    .clk            (clk),
    .reset          (reset),
    .curr_rob_tag   (curr_rob_tag),
    .b_in           (b_in),
    .restore_ack    (restore_ack),
    .flush          (flush),
    .flush_tag      (flush_tag),
    .restore_req    (restore_req),
    .restore_tag    (restore_tag),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_fe       (stall_fe),
    .busy           (busy)
`ifdef BRU_PERF_CNT_EN
    ,
    .mispredict_cnt (mispredict_cnt),
    .hit_cnt        (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic done, input logic mp, input logic [4:0] t,
                    input logic [31:0] p, input logic h);
    b_in.fu_b_done      = done;
    b_in.mispredict     = mp;
    b_in.mispredict_tag = t;
    b_in.pc             = p;
    b_in.hit            = h;
    b_in.hit_tag        = 5'd0;
  endtask

  task automatic idle_in();
    br(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    curr_rob_tag = 5'd0;
    restore_ack  = 1'b0;
    idle_in();
    #12;
    chk("rst_flush", flush, 32'd0);
    chk("rst_flush_tag", flush_tag, 32'd0);
    chk("rst_restore_req", restore_req, 32'd0);
    chk("rst_redirect_valid", redirect_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    br(1'b1, 1'b1, 5'd5, 32'h100, 1'b0);
    #1;
    chk("rst_accept_no_stall", stall_fe, 32'd0);
    idle_in();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Nominal recovery: head 0, tag 5, pc 0x100, ack in third RESTORE cycle
    br(1'b1, 1'b1, 5'd5, 32'h100, 1'b0);
    #1;
    chk("s1_stall_comb", stall_fe, 32'd1);
    chk("s1_busy_idle", busy, 32'd0);
    tick(); idle_in(); #1;
    chk("s1_flush", flush, 32'd1);
    chk("s1_flush_tag", flush_tag, 32'd5);
    chk("s1_flush_no_restore", restore_req, 32'd0);
    chk("s1_busy", busy, 32'd1);
    tick();
    chk("s1_flush_one_cycle", flush, 32'd0);
    chk("s1_flush_tag_zero", flush_tag, 32'd0);
    chk("s1_restore_req", restore_req, 32'd1);
    chk("s1_restore_tag", restore_tag, 32'd5);
    tick();
    chk("s1_restore_hold2", restore_req, 32'd1);
    tick();
    chk("s1_restore_hold3", restore_req, 32'd1);
    chk("s1_no_redirect_yet", redirect_valid, 32'd0);
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0; #1;
    chk("s1_redirect_valid", redirect_valid, 32'd1);
    chk("s1_redirect_pc", redirect_pc, 32'h100);
    chk("s1_restore_dropped", restore_req, 32'd0);
    chk("s1_restore_tag_zero", restore_tag, 32'd0);
    tick();
    chk("s1_idle_busy", busy, 32'd0);
    chk("s1_redirect_one_cycle", redirect_valid, 32'd0);
    chk("s1_redirect_pc_zero", redirect_pc, 32'd0);
    chk("s1_idle_stall", stall_fe, 32'd0);

    // Hit-only result and stray ack in IDLE do nothing
    br(1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    restore_ack = 1'b1; #1;
    chk("hit_no_stall", stall_fe, 32'd0);
    tick(); idle_in(); restore_ack = 1'b0; #1;
    chk("hit_stays_idle", busy, 32'd0);
    chk("hit_no_flush", flush, 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("perf_mispredict_cnt", mispredict_cnt, 32'd1);
    chk("perf_hit_cnt", hit_cnt, 32'd1);
`endif

    // Younger mispredict during RESTORE is ignored
    br(1'b1, 1'b1, 5'd5, 32'h100, 1'b0); #1;
    tick(); idle_in(); tick();
    br(1'b1, 1'b1, 5'd9, 32'h900, 1'b0); #1;
    chk("s2_restore_still", restore_req, 32'd1);
    tick(); idle_in(); #1;
    chk("s2_young_no_flush", flush, 32'd0);
    chk("s2_restore_tag_kept", restore_tag, 32'd5);
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0; #1;
    chk("s2_redirect_pc", redirect_pc, 32'h100);
    tick();
    chk("s2_idle", busy, 32'd0);

    // Older mispredict during RESTORE replaces the recovery
    br(1'b1, 1'b1, 5'd5, 32'h100, 1'b0); #1;
    tick(); idle_in(); tick();
    br(1'b1, 1'b1, 5'd3, 32'h80, 1'b0); #1;
    tick(); idle_in(); #1;
    chk("s3_reflush", flush, 32'd1);
    chk("s3_reflush_tag", flush_tag, 32'd3);
    chk("s3_reflush_no_restore", restore_req, 32'd0);
    tick();
    chk("s3_restore_tag", restore_tag, 32'd3);
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0; #1;
    chk("s3_redirect_pc", redirect_pc, 32'h80);
    tick();
    chk("s3_idle", busy, 32'd0);

    // Wrap: head 30, tag_q 1 (age 3); 29 is age 31, 31 is age 1
    curr_rob_tag = 5'd30;
    br(1'b1, 1'b1, 5'd1, 32'h200, 1'b0); #1;
    tick(); idle_in(); #1;
    chk("s4_flush_tag", flush_tag, 32'd1);
    tick();
    br(1'b1, 1'b1, 5'd29, 32'hbad, 1'b0); #1;
    tick(); idle_in(); #1;
    chk("s4_young_no_flush", flush, 32'd0);
    chk("s4_restore_tag_kept", restore_tag, 32'd1);
    br(1'b1, 1'b1, 5'd31, 32'h300, 1'b0); #1;
    tick(); idle_in(); #1;
    chk("s4_wrap_reflush", flush, 32'd1);
    chk("s4_wrap_flush_tag", flush_tag, 32'd31);
    tick();
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0; #1;
    chk("s4_redirect_pc", redirect_pc, 32'h300);
    tick();
    chk("s4_idle", busy, 32'd0);
    curr_rob_tag = 5'd0;

    // Older mispredict in REDIRECT kills the pending redirect
    br(1'b1, 1'b1, 5'd10, 32'ha00, 1'b0); #1;
    tick(); idle_in(); tick();
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0; #1;
    chk("s5_redirect_before", redirect_valid, 32'd1);
    br(1'b1, 1'b1, 5'd4, 32'h400, 1'b0); #1;
    chk("s5_redirect_killed", redirect_valid, 32'd0);
    chk("s5_redirect_pc_zero", redirect_pc, 32'd0);
    tick(); idle_in(); #1;
    chk("s5_flush_follows", flush, 32'd1);
    chk("s5_flush_tag", flush_tag, 32'd4);
    tick();
    restore_ack = 1'b1; #1;
    tick(); restore_ack = 1'b0;
    br(1'b1, 1'b1, 5'd20, 32'h2000, 1'b0); #1;
    chk("s5_young_keeps_redirect", redirect_valid, 32'd1);
    chk("s5_young_redirect_pc", redirect_pc, 32'h400);
    tick(); idle_in(); #1;
    chk("s5_idle", busy, 32'd0);
    chk("s5_young_no_flush", flush, 32'd0);

    // Asynchronous reset in RESTORE
    br(1'b1, 1'b1, 5'd7, 32'h700, 1'b0); #1;
    tick(); idle_in(); tick();
    chk("s6_restore_req", restore_req, 32'd1);
    chk("s6_stall", stall_fe, 32'd1);
    reset = 1'b0; #1;
    chk("s6_async_restore_req", restore_req, 32'd0);
    chk("s6_async_stall", stall_fe, 32'd0);
    chk("s6_async_busy", busy, 32'd0);
    chk("s6_async_restore_tag", restore_tag, 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("s6_perf_cnt_clear", mispredict_cnt, 32'd0);
`endif
    restore_ack = 1'b1;
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s6_no_redirect", redirect_valid, 32'd0);
      chk("s6_no_flush", flush, 32'd0);
      chk("s6_stay_idle", busy, 32'd0);
    end
    restore_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
